// File: rtl/br_pkg.sv
// Shared definitions for the branch resolution unit: condition codes,
// prediction counter states, fixed immediate widths and the counter
// update rule used by the branch history table.
package br_pkg;

    localparam int OFFSET_W    = 16;
    localparam int INSTR_IDX_W = 26;
    localparam int CB_W        = 4;

    // Condition codes carried on ex_cb; any code not listed acts as NONE.
    typedef enum logic [CB_W-1:0] {
        CB_NONE = 4'd0,
        CB_BEQ  = 4'd1,
        CB_BNE  = 4'd2,
        CB_BLEZ = 4'd3,
        CB_BGTZ = 4'd4,
        CB_BLTZ = 4'd5,
        CB_BGEZ = 4'd6,
        CB_J    = 4'd7,
        CB_JR   = 4'd8
    } cb_e;

    // Two-bit saturating predictor states; the MSB is the prediction.
    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    // Saturating step towards the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: array of 2-bit saturating counters.
// Latency: read is combinational; update lands on the next clk edge (read-before-write).
// Backpressure: none, one lookup and one update accepted every cycle.
module br_bht
    import br_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_upd_vld,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    logic [1:0] r_ctr [DEPTH];

    // Reset every counter to weak-not-taken, otherwise step the addressed one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctr[i] <= CTR_RESET;
            end
        end else if (i_upd_vld) begin
            r_ctr[i_upd_idx] <= ctr_next(r_ctr[i_upd_idx], i_upd_taken);
        end
    end

    // The array is read before the edge writes it, so a same-index lookup sees the old value.
    assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule

// File: rtl/br_unit.sv
// Branch resolution unit with 2-bit BHT prediction; optional statistics via BR_STATS_EN.
// Latency: operands sampled at one clk edge, registered result visible for the following cycle.
// Backpressure: none, an operation can be presented every cycle; flush kills the one presented.
module br_unit
    import br_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH),
    parameter int STAT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [XLEN-1:0]        f_pc,
    output logic                   f_pred_taken,
    input  logic                   ex_valid,
    input  logic [CB_W-1:0]        ex_cb,
    input  logic [XLEN-1:0]        ex_rd1,
    input  logic [XLEN-1:0]        ex_rd2,
    input  logic [OFFSET_W-1:0]    ex_offset,
    input  logic [INSTR_IDX_W-1:0] ex_instr_index,
    input  logic [XLEN-1:0]        ex_pc,
    input  logic                   ex_pred_taken,
    input  logic                   flush,
    output logic                   redir_valid,
    output logic [XLEN-1:0]        redir_pc,
    output logic                   taken,
    output logic                   mispredict,
    output logic [STAT_W-1:0]      stat_branches,
    output logic [STAT_W-1:0]      stat_mispredicts
);

    logic            w_is_cond;
    logic            w_is_jump;
    logic            w_cond_true;
    logic [XLEN-1:0] w_jump_tgt;
    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_fall_thru;
    logic            w_accept;
    logic            w_taken;
    logic            w_mispredict;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_rd1_neg;
    logic            w_rd1_zero;
    logic [1:0]      w_rd_ctr;
    logic            w_unused_ok;

    logic            r_taken;
    logic            r_mispredict;
    logic [XLEN-1:0] r_redir_pc;

    assign w_rd1_neg   = ex_rd1[XLEN-1];
    assign w_rd1_zero  = (ex_rd1 == '0);
    assign w_fall_thru = ex_pc + XLEN'(4);
    assign w_br_tgt    = w_fall_thru
                       + {{(XLEN-OFFSET_W-2){ex_offset[OFFSET_W-1]}}, ex_offset, 2'b00};

    // Decode the condition code into class, condition outcome and jump target.
    always_comb begin
        w_is_cond   = 1'b0;
        w_is_jump   = 1'b0;
        w_cond_true = 1'b0;
        w_jump_tgt  = '0;
        case (ex_cb)
            CB_BEQ:  begin w_is_cond = 1'b1; w_cond_true = (ex_rd1 == ex_rd2); end
            CB_BNE:  begin w_is_cond = 1'b1; w_cond_true = (ex_rd1 != ex_rd2); end
            CB_BLEZ: begin w_is_cond = 1'b1; w_cond_true = w_rd1_neg | w_rd1_zero; end
            CB_BGTZ: begin w_is_cond = 1'b1; w_cond_true = ~w_rd1_neg & ~w_rd1_zero; end
            CB_BLTZ: begin w_is_cond = 1'b1; w_cond_true = w_rd1_neg; end
            CB_BGEZ: begin w_is_cond = 1'b1; w_cond_true = ~w_rd1_neg; end
            CB_J:    begin w_is_jump = 1'b1; w_jump_tgt = {ex_pc[XLEN-1:28], ex_instr_index, 2'b00}; end
            CB_JR:   begin w_is_jump = 1'b1; w_jump_tgt = ex_rd1; end
            default: ;
        endcase
    end

    // A flush or a NONE/unused code produces no result at all.
    assign w_accept     = ex_valid & ~flush & (w_is_cond | w_is_jump);
    assign w_taken      = w_is_jump | w_cond_true;
    assign w_mispredict = w_is_jump ? ~ex_pred_taken : (w_cond_true != ex_pred_taken);
    assign w_redir_pc   = !w_taken  ? w_fall_thru
                        : w_is_jump ? w_jump_tgt : w_br_tgt;

    // Output register holds a result for exactly one cycle; anything not accepted clears it.
    always_ff @(posedge clk) begin
        if (rst || !w_accept) begin
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_redir_pc   <= '0;
        end else begin
            r_taken      <= w_taken;
            r_mispredict <= w_mispredict;
            r_redir_pc   <= w_redir_pc;
        end
    end

    assign taken       = r_taken;
    assign mispredict  = r_mispredict;
    assign redir_valid = r_mispredict;
    assign redir_pc    = r_redir_pc;

    br_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (f_pc[IDX_W+1:2]),
        .o_rd_ctr    (w_rd_ctr),
        .i_upd_vld   (w_accept & w_is_cond),
        .i_upd_idx   (ex_pc[IDX_W+1:2]),
        .i_upd_taken (w_cond_true)
    );

    assign f_pred_taken = w_rd_ctr[1];

`ifdef BR_STATS_EN
    logic [STAT_W-1:0] r_stat_branches;
    logic [STAT_W-1:0] r_stat_mispredicts;

    // Count resolved operations and their mispredictions, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_accept) begin
            r_stat_branches    <= r_stat_branches + STAT_W'(1);
            r_stat_mispredicts <= r_stat_mispredicts + STAT_W'(w_mispredict);
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

    // Only the index bits of the fetch PC address the table.
    assign w_unused_ok = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};

endmodule

// File: tb/tb_br_unit.sv
// Self-checking bench for br_unit: directed cases plus randomized traffic
// against a behavioural model of resolution, prediction table and statistics.
module tb_br_unit;
    import br_pkg::*;

    localparam int XLEN = 32;
    localparam int DEPTH = 64;
    localparam int STAT_W = 32;

    logic        clk;
    logic        rst;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic        ex_valid;
    logic [3:0]  ex_cb;
    logic [31:0] ex_rd1, ex_rd2, ex_pc;
    logic [15:0] ex_offset;
    logic [25:0] ex_instr_index;
    logic        ex_pred_taken;
    logic        flush;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        taken;
    logic        mispredict;
    logic [31:0] stat_branches, stat_mispredicts;

    br_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .ex_valid(ex_valid), .ex_cb(ex_cb), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_offset(ex_offset), .ex_instr_index(ex_instr_index), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .flush(flush), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .taken(taken), .mispredict(mispredict),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int          bht [DEPTH];
    logic        e_taken, e_mp;
    logic [31:0] e_pc;
    logic [31:0] e_br, e_mpc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tbl_idx(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    // Model the effect of one presented operation at the coming edge.
    task automatic model_step(input logic r, input logic v, input logic fl, input logic [3:0] cb,
                              input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] pc,
                              input logic [15:0] off, input logic [25:0] idx, input logic pr);
        logic               is_cond, is_jump, tk;
        logic [31:0]        tgt;
        logic signed [31:0] soff;
        logic signed [31:0] srd1;
        int                 k;
        is_cond = 1'b0; is_jump = 1'b0; tk = 1'b0; tgt = 32'h0;
        soff = $signed(off);
        srd1 = $signed(rd1);
        case (cb)
            4'd1: begin is_cond = 1; tk = (rd1 == rd2); end
            4'd2: begin is_cond = 1; tk = (rd1 != rd2); end
            4'd3: begin is_cond = 1; tk = (srd1 <= 0); end
            4'd4: begin is_cond = 1; tk = (srd1 > 0); end
            4'd5: begin is_cond = 1; tk = (srd1 < 0); end
            4'd6: begin is_cond = 1; tk = (srd1 >= 0); end
            4'd7: begin is_jump = 1; tk = 1; tgt = (pc & 32'hF000_0000) | ({6'd0, idx} * 4); end
            4'd8: begin is_jump = 1; tk = 1; tgt = rd1; end
            default: ;
        endcase
        if (is_cond) tgt = pc + 32'd4 + 32'(soff * 4);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) bht[i] = 1;
            e_taken = 0; e_mp = 0; e_pc = 0; e_br = 0; e_mpc = 0;
        end else if (v && !fl && (is_cond || is_jump)) begin
            e_taken = tk;
            e_pc    = tk ? tgt : pc + 32'd4;
            e_mp    = is_cond ? (tk != pr) : !pr;
            e_br    = e_br + 1;
            e_mpc   = e_mpc + (e_mp ? 1 : 0);
            if (is_cond) begin
                k = tbl_idx(pc);
                if (tk && bht[k] < 3) bht[k] = bht[k] + 1;
                if (!tk && bht[k] > 0) bht[k] = bht[k] - 1;
            end
        end else begin
            e_taken = 0; e_mp = 0; e_pc = 0;
        end
    endtask

    // Compare every output against the model; called once per cycle at the negedge.
    task automatic compare_outputs();
        chk("taken", taken, e_taken);
        chk("redir_pc", redir_pc, e_pc);
        chk("mispredict", mispredict, e_mp);
        chk("redir_valid", redir_valid, e_mp);
`ifdef BR_STATS_EN
        chk("stat_branches", stat_branches, e_br);
        chk("stat_mispredicts", stat_mispredicts, e_mpc);
`else
        chk("stat_branches", stat_branches, 32'h0);
        chk("stat_mispredicts", stat_mispredicts, 32'h0);
`endif
    endtask

    // Present one cycle of inputs (called at a negedge), check lookup, then check results.
    task automatic cycle(input logic r, input logic v, input logic fl, input logic [3:0] cb,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] pc,
                         input logic [15:0] off, input logic [25:0] idx, input logic pr,
                         input logic [31:0] fpc);
        rst = r; ex_valid = v; flush = fl; ex_cb = cb; ex_rd1 = rd1; ex_rd2 = rd2;
        ex_pc = pc; ex_offset = off; ex_instr_index = idx; ex_pred_taken = pr; f_pc = fpc;
        #1;
        chk("f_pred_taken", f_pred_taken, bht[tbl_idx(fpc)] >= 2);
        model_step(r, v, fl, cb, rd1, rd2, pc, off, idx, pr);
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input logic [31:0] fpc);
        cycle(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, fpc);
    endtask

    function automatic logic [31:0] rand_rd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h5;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
        return 32'h1000 + 32'($urandom_range(0, 7)) * 4;
    endfunction

    logic [31:0] sb, sm;
    logic [31:0] rpc;

    initial begin
        rst = 1; ex_valid = 0; flush = 0; ex_cb = 0; ex_rd1 = 0; ex_rd2 = 0; ex_pc = 0;
        ex_offset = 0; ex_instr_index = 0; ex_pred_taken = 0; f_pc = 0;
        e_taken = 0; e_mp = 0; e_pc = 0; e_br = 0; e_mpc = 0;
        for (int i = 0; i < DEPTH; i++) bht[i] = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset state
        compare_outputs();
        chk("reset_pred", f_pred_taken, 1'b0);

        // BEQ taken backwards to itself, predicted not-taken
        cycle(0, 1, 0, CB_BEQ, 5, 5, 32'h100, 16'hFFFF, 0, 0, 0);
        chk("beq_taken", taken, 1'b1);
        chk("beq_pc", redir_pc, 32'h100);
        chk("beq_mp", mispredict, 1'b1);

        // BLTZ on most negative value, predicted taken
        cycle(0, 1, 0, CB_BLTZ, 32'h8000_0000, 0, 32'h200, 16'h4, 0, 1, 0);
        chk("bltz_taken", taken, 1'b1);
        chk("bltz_mp", mispredict, 1'b0);
        chk("bltz_pc", redir_pc, 32'h214);

        // Output lasts one cycle only
        idle(32'h40);
        chk("one_cycle_taken", taken, 1'b0);
        chk("pred_before_train", f_pred_taken, 1'b0);

        // Train one index with three taken BNEs
        cycle(0, 1, 0, CB_BNE, 1, 2, 32'h40, 16'h8, 0, 0, 32'h40);
        chk("bht_after1", f_pred_taken, 1'b1);
        cycle(0, 1, 0, CB_BNE, 1, 2, 32'h40, 16'h8, 0, 1, 32'h40);
        cycle(0, 1, 0, CB_BNE, 1, 2, 32'h40, 16'h8, 0, 1, 32'h40);
        chk("bht_after3", f_pred_taken, 1'b1);
        chk("model_ctr_sat", bht[16], 3);

        // JR killed by flush: nothing, stats frozen
        sb = stat_branches; sm = stat_mispredicts;
        cycle(0, 1, 1, CB_JR, 32'h0040_0000, 0, 32'h300, 0, 0, 0, 0);
        chk("flush_taken", taken, 1'b0);
        chk("flush_pc", redir_pc, 32'h0);
        chk("flush_rv", redir_valid, 1'b0);
        chk("flush_stat_b", stat_branches, sb);
        chk("flush_stat_m", stat_mispredicts, sm);

        // Jump target region and PC wrap
        cycle(0, 1, 0, CB_J, 0, 0, 32'hF000_0000, 0, 26'h3FF_FFFF, 1, 0);
        chk("j_pc", redir_pc, 32'hFFFF_FFFC);
        cycle(0, 1, 0, CB_BEQ, 1, 2, 32'hFFFF_FFFC, 16'h10, 0, 0, 0);
        chk("wrap_pc", redir_pc, 32'h0);
        chk("wrap_taken", taken, 1'b0);

        // Reset while a branch is in flight and another is presented
        cycle(0, 1, 0, CB_BGEZ, 0, 0, 32'h40, 16'h2, 0, 0, 0);
        cycle(1, 1, 0, CB_BGEZ, 0, 0, 32'h44, 16'h2, 0, 0, 0);
        chk("rst_taken", taken, 1'b0);
        chk("rst_pc", redir_pc, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            idle(32'(i * 4));
        end
        chk("rst_pred_trained_idx", bht[16], 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rpc = rand_pc();
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 10)),
                  rand_rd(), rand_rd(), rpc, 16'($urandom), 26'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0) ? rpc : rand_pc());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
